// File: rtl/mem_access_controller_pkg.sv
// Shared constants, FSM encoding and address-window helpers for the memory access controller.
package mem_access_controller_pkg;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_DEPTH_WORDS = 64;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Inclusive byte-address window accepted by the fault check.
  function automatic logic [31:0] addr_lo(input int unsigned base);
    return 32'(base);
  endfunction

  function automatic logic [31:0] addr_hi(input int unsigned base, input int unsigned depth);
    return 32'(base + 4 * depth - 1);
  endfunction

endpackage

// File: rtl/mem_access_controller_latency_counter.sv
// Loadable 4-bit down-counter that saturates at zero; zero flag ends an access.
module latency_counter
  import mem_access_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_controller.sv
// Multi-cycle load/store sequencer between the pipeline and a fixed-latency data memory.
module mem_access_controller
  import mem_access_controller_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] alu_result,
  input  logic [31:0] val_rm,
  output logic        memoryRead,
  output logic        memoryWrite,
  output logic [31:0] address,
  output logic [31:0] data_in,
  input  logic [31:0] data,
  output logic        freeze,
  output logic [31:0] mem_result,
  output logic        mem_result_valid,
  output logic        addr_fault
);

  localparam logic [31:0]      ADDR_LO  = addr_lo(BASE_ADDR);
  localparam logic [31:0]      ADDR_HI  = addr_hi(BASE_ADDR, DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      result_q, result_d;
  logic             is_read_q, is_read_d;
  logic             req_any, req_ok;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt;

  assign req_any = mem_read_en | mem_write_en;
  assign req_ok  = (mem_read_en ^ mem_write_en) && (alu_result[1:0] == 2'b00) &&
                   (alu_result >= ADDR_LO) && (alu_result <= ADDR_HI);

  latency_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    is_read_d        = is_read_q;
    result_d         = result_q;
    cnt_load         = 1'b0;
    cnt_dec          = 1'b0;
    freeze           = 1'b0;
    addr_fault       = 1'b0;
    memoryRead       = 1'b0;
    memoryWrite      = 1'b0;
    address          = '0;
    data_in          = '0;
    mem_result_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Request decode is combinational, so keep it quiet while reset is held.
        if (!rst) begin
          if (req_ok) begin
            freeze    = 1'b1;
            cnt_load  = 1'b1;
            addr_d    = alu_result;
            wdata_d   = val_rm;
            is_read_d = mem_read_en;
            state_d   = ST_ACCESS;
          end else if (req_any) begin
            addr_fault = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        freeze      = 1'b1;
        address     = addr_q;
        data_in     = wdata_q;
        cnt_dec     = !cnt_zero;
        memoryRead  = is_read_q;
        memoryWrite = !is_read_q && cnt_zero;
        if (cnt_zero) begin
          state_d = ST_DONE;
          if (is_read_q) result_d = data;
        end
      end
      ST_DONE: begin
        mem_result_valid = is_read_q;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
      is_read_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      result_q  <= result_d;
      is_read_q <= is_read_d;
    end
  end

  assign mem_result = result_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench: fault/accept vector table plus hand-timed store, load, reset-abort and latency-1 streams.
module tb_mem_access_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd, wr;
  logic [31:0] addr, vrm, data;
  logic        mr, mw, frz, vld, flt;
  logic [31:0] ad, di, res;

  logic        rd1;
  logic [31:0] addr1, data1;
  logic        mr1, mw1, frz1, vld1, flt1;
  logic [31:0] ad1, di1, res1;

  mem_access_controller #(.MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .mem_read_en(rd), .mem_write_en(wr), .alu_result(addr),
    .val_rm(vrm), .memoryRead(mr), .memoryWrite(mw), .address(ad), .data_in(di),
    .data(data), .freeze(frz), .mem_result(res), .mem_result_valid(vld), .addr_fault(flt)
  );

  mem_access_controller #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read_en(rd1), .mem_write_en(1'b0), .alu_result(addr1),
    .val_rm(32'h0), .memoryRead(mr1), .memoryWrite(mw1), .address(ad1), .data_in(di1),
    .data(data1), .freeze(frz1), .mem_result(res1), .mem_result_valid(vld1), .addr_fault(flt1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       nm;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_fault;
    logic        exp_frz;
  } vec_t;

  vec_t vt[7];

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; vrm = '0; data = '0;
    rd1 = 1'b0; addr1 = '0; data1 = '0;

    vt[0] = '{"misaligned_1022",   1'b1, 1'b0, 32'd1022, 32'h0,        1'b1, 1'b0};
    vt[1] = '{"out_of_range_1280", 1'b0, 1'b1, 32'd1280, 32'h11111111, 1'b1, 1'b0};
    vt[2] = '{"below_base_1020",   1'b1, 1'b0, 32'd1020, 32'h0,        1'b1, 1'b0};
    vt[3] = '{"both_en_1024",      1'b1, 1'b1, 32'd1024, 32'h22222222, 1'b1, 1'b0};
    vt[4] = '{"misaligned_1279",   1'b1, 1'b0, 32'd1279, 32'h0,        1'b1, 1'b0};
    vt[5] = '{"last_word_1276",    1'b0, 1'b1, 32'd1276, 32'h33333333, 1'b0, 1'b1};
    vt[6] = '{"first_word_1024",   1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 1'b1};

    step; step;
    // reset held with a request present: everything quiet
    rd = 1'b1; addr = 32'd1028; #1;
    chk("rst_freeze", 32'(frz), 0);
    chk("rst_fault", 32'(flt), 0);
    chk("rst_mread", 32'(mr), 0);
    chk("rst_address", ad, 0);
    chk("rst_result", res, 0);
    chk("rst_valid", 32'(vld), 0);
    rd = 1'b0;
    step;
    rst = 1'b0;

    // store accepted in the first cycle after reset
    wr = 1'b1; addr = 32'd1028; vrm = 32'h12345678; #1;
    chk("st_req_freeze", 32'(frz), 1);
    chk("st_req_mwrite", 32'(mw), 0);
    chk("st_req_address", ad, 0);
    step;
    wr = 1'b0; rd = 1'b1; addr = 32'd2000; vrm = 32'hFFFFFFFF; #1;
    chk("st_a1_freeze", 32'(frz), 1);
    chk("st_a1_mwrite", 32'(mw), 0);
    chk("st_a1_mread", 32'(mr), 0);
    chk("st_a1_address", ad, 32'd1028);
    chk("st_a1_data_in", di, 32'h12345678);
    chk("st_a1_fault", 32'(flt), 0);
    step;
    chk("st_a2_mwrite", 32'(mw), 1);
    chk("st_a2_freeze", 32'(frz), 1);
    chk("st_a2_address", ad, 32'd1028);
    chk("st_a2_data_in", di, 32'h12345678);
    step;
    chk("st_done_freeze", 32'(frz), 0);
    chk("st_done_mwrite", 32'(mw), 0);
    chk("st_done_valid", 32'(vld), 0);
    chk("st_done_address", ad, 0);
    chk("st_done_data_in", di, 0);
    chk("st_done_fault", 32'(flt), 0);
    rd = 1'b0; addr = '0; vrm = '0;
    step;
    chk("st_idle_freeze", 32'(frz), 0);
    chk("st_idle_mwrite", 32'(mw), 0);

    // load
    data = 32'hCAFEF00D; rd = 1'b1; addr = 32'd1028; #1;
    chk("ld_req_freeze", 32'(frz), 1);
    chk("ld_req_mread", 32'(mr), 0);
    step;
    rd = 1'b0; #1;
    chk("ld_a1_mread", 32'(mr), 1);
    chk("ld_a1_address", ad, 32'd1028);
    chk("ld_a1_freeze", 32'(frz), 1);
    step;
    chk("ld_a2_mread", 32'(mr), 1);
    chk("ld_a2_freeze", 32'(frz), 1);
    step;
    chk("ld_done_result", res, 32'hCAFEF00D);
    chk("ld_done_valid", 32'(vld), 1);
    chk("ld_done_freeze", 32'(frz), 0);
    chk("ld_done_mread", 32'(mr), 0);
    step;
    chk("ld_idle_valid", 32'(vld), 0);
    chk("ld_idle_result", res, 32'hCAFEF00D);

    // vector table: fault pulses vs accepted requests
    foreach (vt[i]) begin
      rd = vt[i].rd; wr = vt[i].wr; addr = vt[i].addr; vrm = vt[i].wd; #1;
      chk({vt[i].nm, "_fault"}, 32'(flt), 32'(vt[i].exp_fault));
      chk({vt[i].nm, "_freeze"}, 32'(frz), 32'(vt[i].exp_frz));
      chk({vt[i].nm, "_mread"}, 32'(mr), 0);
      chk({vt[i].nm, "_mwrite"}, 32'(mw), 0);
      step;
      rd = 1'b0; wr = 1'b0; addr = '0; vrm = '0; #1;
      chk({vt[i].nm, "_next_freeze"}, 32'(frz), 32'(vt[i].exp_frz));
      chk({vt[i].nm, "_next_fault"}, 32'(flt), 0);
      repeat (3) step;
    end
    chk("result_held_over_write", res, 32'hCAFEF00D);

    // reset in the first ACCESS cycle of a store aborts it
    wr = 1'b1; addr = 32'd1032; vrm = 32'hDEADBEEF; #1;
    chk("ab_req_freeze", 32'(frz), 1);
    step;
    wr = 1'b0; addr = '0; vrm = '0; #1;
    chk("ab_a1_address", ad, 32'd1032);
    chk("ab_a1_mwrite", 32'(mw), 0);
    rst = 1'b1; #1;
    chk("ab_rst_freeze", 32'(frz), 0);
    chk("ab_rst_address", ad, 0);
    chk("ab_rst_data_in", di, 0);
    chk("ab_rst_mwrite", 32'(mw), 0);
    chk("ab_rst_result", res, 0);
    chk("ab_rst_valid", 32'(vld), 0);
    step;
    chk("ab_rst_c1_mwrite", 32'(mw), 0);
    step;
    rst = 1'b0;
    data = 32'h0BADF00D; rd = 1'b1; addr = 32'd1032; #1;
    chk("ab_ld_req_freeze", 32'(frz), 1);
    chk("ab_ld_req_mwrite", 32'(mw), 0);
    step;
    rd = 1'b0; addr = '0; #1;
    chk("ab_ld_a1_mread", 32'(mr), 1);
    chk("ab_ld_a1_mwrite", 32'(mw), 0);
    step;
    chk("ab_ld_a2_mwrite", 32'(mw), 0);
    step;
    chk("ab_ld_done_result", res, 32'h0BADF00D);
    chk("ab_ld_done_valid", 32'(vld), 1);
    step;

    // latency 1, loads held high back to back: freeze 1,1,0 repeating
    rd1 = 1'b1; addr1 = 32'd1040;
    for (int k = 0; k < 9; k++) begin
      data1 = 32'hA0000000 + 32'(k); #1;
      chk($sformatf("l1_freeze_c%0d", k), 32'(frz1), 32'((k % 3) != 2));
      chk($sformatf("l1_mread_c%0d", k), 32'(mr1), 32'((k % 3) == 1));
      chk($sformatf("l1_fault_c%0d", k), 32'(flt1), 0);
      if ((k % 3) == 2) begin
        chk($sformatf("l1_result_c%0d", k), res1, 32'hA0000000 + 32'(k - 1));
        chk($sformatf("l1_valid_c%0d", k), 32'(vld1), 1);
      end else begin
        chk($sformatf("l1_novalid_c%0d", k), 32'(vld1), 0);
      end
      step;
    end
    rd1 = 1'b0;
    step;
    chk("l1_mwrite_never", 32'(mw1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
